// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state encoding and default width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'b11 is deliberately unused; the controller treats it as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_bit_add_cell.sv
// One-bit full adder assembled from two half-adder stages; the two stage carries are ORed.
module bit_add_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = x ^ y;
    assign ha0_c = x & y;
    assign s     = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared add cell, LSB first, one bit per clock, start/done handshake.
// Optional subtract mode (extra 'sub' input) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] psum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cy_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             s_d;
    logic             cy_d;
    logic [WIDTH-1:0] psum_d;
    logic [WIDTH-1:0] b_load_d;
    logic             cy_init_d;

    bit_add_cell u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (cy_q),
        .s  (s_d),
        .co (cy_d)
    );

    // New bit enters at the MSB; after WIDTH shifts the full word is LSB-aligned.
    assign psum_d = {s_d, psum_q};

`ifdef SERIAL_ADD_SUB_EN
    assign b_load_d  = sub ? ~b : b;
    assign cy_init_d = sub;
`else
    assign b_load_d  = b;
    assign cy_init_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b_load_d;
                        cy_q    <= cy_init_d;
                        cnt_q   <= '0;
                        psum_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    cy_q   <= cy_d;
                    psum_q <= psum_d[WIDTH-1:1];
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= psum_d;
                        carry_q <= cy_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule
